// File: rtl/plot_sink_pkg.sv
// Shared geometry, types and helpers for the plot_sink framebuffer.
package plot_sink_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned FB_DEPTH = 19200;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned CNT_W    = 15;

   typedef logic [2:0]        colour_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef enum logic [0:0] {
      StInit   = 1'b0,
      StActive = 1'b1
   } state_e;

   localparam addr_t LAST_ADDR = addr_t'(FB_DEPTH - 1);
   localparam cnt_t  CNT_MAX   = '1;

   function automatic logic in_screen(input logic [7:0] x, input logic [6:0] y);
      return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
   endfunction

   // Full 15-bit product: y<=127 and x<=255 never exceed 20575.
   function automatic addr_t pix_addr(input logic [7:0] x, input logic [6:0] y);
      return ({8'd0, y} * addr_t'(SCREEN_W)) + {7'd0, x};
   endfunction

   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == CNT_MAX) ? c : c + cnt_t'(1);
   endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
module fb_ram
   import plot_sink_pkg::*;
(
   input  logic    clk_i,
   input  logic    we_i,
   input  addr_t   waddr_i,
   input  colour_t wdata_i,
   input  addr_t   raddr_i,
   output colour_t rdata_o
);

   colour_t mem [FB_DEPTH];
   colour_t rdata_d, rdata_q;

   always_comb begin
      rdata_d = mem[raddr_i];
   end

   // Read returns the old contents on a same-address write; the top handles bypass.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/plot_sink.sv
// Framebuffer sink: INIT sweep, pixel plotting, one-cycle readback with write-first bypass.
// Define PLOT_SINK_STATS_EN to build the plot/out-of-range counters.
module plot_sink
   import plot_sink_pkg::*;
#(
   parameter logic [2:0] INIT_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_x,
   input  logic [6:0]  vga_y,
   input  logic [2:0]  vga_colour,
   input  logic        vga_plot,
   input  logic        clr,
   input  logic        rd_req,
   input  logic [7:0]  rd_x,
   input  logic [6:0]  rd_y,
   output logic        rd_valid,
   output logic [2:0]  rd_colour,
   output logic        busy,
   output logic [14:0] plot_count,
   output logic [14:0] oob_count
);

   state_e  state_q, state_d;
   addr_t   sweep_q, sweep_d;
   logic    rd_valid_q, rd_valid_d;
   logic    rd_dflt_q, rd_dflt_d;
   logic    byp_q, byp_d;
   colour_t byp_col_q, byp_col_d;

   logic    plot_in, rd_in, plot_ok;
   addr_t   plot_addr, rd_addr, ram_raddr;
   logic    we;
   addr_t   waddr;
   colour_t wdata;
   colour_t ram_rdata;

   assign plot_in   = in_screen(vga_x, vga_y);
   assign rd_in     = in_screen(rd_x, rd_y);
   assign plot_addr = pix_addr(vga_x, vga_y);
   assign rd_addr   = pix_addr(rd_x, rd_y);
   assign ram_raddr = rd_in ? rd_addr : '0;

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      we      = 1'b0;
      waddr   = sweep_q;
      wdata   = INIT_COLOUR;
      plot_ok = 1'b0;
      if (clr) begin
         state_d = StInit;
         sweep_d = '0;
      end else if (state_q == StInit) begin
         we = 1'b1;
         if (sweep_q == LAST_ADDR) begin
            state_d = StActive;
            sweep_d = '0;
         end else begin
            sweep_d = sweep_q + addr_t'(1);
         end
      end else if (vga_plot && plot_in) begin
         we      = 1'b1;
         waddr   = plot_addr;
         wdata   = vga_colour;
         plot_ok = 1'b1;
      end
   end

   always_comb begin
      rd_valid_d = rd_req;
      rd_dflt_d  = (state_q == StInit) || !rd_in;
      byp_d      = plot_ok && rd_in && (plot_addr == rd_addr);
      byp_col_d  = vga_colour;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StInit;
         sweep_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_dflt_q  <= 1'b0;
         byp_q      <= 1'b0;
         byp_col_q  <= '0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         rd_valid_q <= rd_valid_d;
         rd_dflt_q  <= rd_dflt_d;
         byp_q      <= byp_d;
         byp_col_q  <= byp_col_d;
      end
   end

   fb_ram u_fb_ram (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign busy     = (state_q == StInit);
   assign rd_valid = rd_valid_q;

   // Idle output is forced to zero so reset shows rd_colour=0 regardless of INIT_COLOUR.
   always_comb begin
      rd_colour = '0;
      if (rd_valid_q) begin
         if (rd_dflt_q) begin
            rd_colour = INIT_COLOUR;
         end else if (byp_q) begin
            rd_colour = byp_col_q;
         end else begin
            rd_colour = ram_rdata;
         end
      end
   end

`ifdef PLOT_SINK_STATS_EN
   cnt_t plot_cnt_q, plot_cnt_d;
   cnt_t oob_cnt_q, oob_cnt_d;
   logic plot_bad;

   assign plot_bad = vga_plot && !clr && ((state_q == StInit) || !plot_in);

   always_comb begin
      plot_cnt_d = plot_cnt_q;
      oob_cnt_d  = oob_cnt_q;
      if (clr) begin
         plot_cnt_d = '0;
         oob_cnt_d  = '0;
      end else begin
         if (plot_ok) begin
            plot_cnt_d = sat_inc(plot_cnt_q);
         end
         if (plot_bad) begin
            oob_cnt_d = sat_inc(oob_cnt_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         plot_cnt_q <= '0;
         oob_cnt_q  <= '0;
      end else begin
         plot_cnt_q <= plot_cnt_d;
         oob_cnt_q  <= oob_cnt_d;
      end
   end

   assign plot_count = plot_cnt_q;
   assign oob_count  = oob_cnt_q;
`else
   assign plot_count = '0;
   assign oob_count  = '0;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Directed self-checking bench for plot_sink; counter expectations follow PLOT_SINK_STATS_EN.
module tb_plot_sink;

`ifdef PLOT_SINK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        clr;
   logic        rd_req;
   logic [7:0]  rd_x;
   logic [6:0]  rd_y;
   logic        rd_valid;
   logic [2:0]  rd_colour;
   logic        busy;
   logic [14:0] plot_count;
   logic [14:0] oob_count;

   int vectors = 0;
   int miscompares = 0;

   plot_sink #(.INIT_COLOUR(3'b000)) dut (
      .clk        (clk),
      .rst        (rst),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .clr        (clr),
      .rd_req     (rd_req),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_valid   (rd_valid),
      .rd_colour  (rd_colour),
      .busy       (busy),
      .plot_count (plot_count),
      .oob_count  (oob_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [14:0] exp_cnt(input int n);
      if (!STATS) return 15'd0;
      return (n > 32767) ? 15'd32767 : 15'(n);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues a one-cycle read and checks the next-cycle result.
   task automatic read_px(input string name, input int x, input int y, input logic [2:0] expc);
      rd_req = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
      tick();
      rd_req = 1'b0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_colour !== expc) begin
         miscompares++;
         $display("FAIL %s: got valid=%0b colour=%0d expected valid=1 colour=%0d",
                  name, rd_valid, rd_colour, expc);
      end
   endtask

   task automatic plot_px(input int x, input int y, input logic [2:0] c);
      vga_plot = 1'b1; vga_x = 8'(x); vga_y = 7'(y); vga_colour = c;
      tick();
      vga_plot = 1'b0;
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      while (busy === 1'b1 && n < 40000) begin
         n++;
         tick();
      end
      vectors++;
      if (n != 19200) begin
         miscompares++;
         $display("FAIL %s: got busy cycles=%0d expected 19200", name, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
      clr = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
      repeat (3) tick();
      vectors++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_colour !== 3'd0 ||
          plot_count !== 15'd0 || oob_count !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%0b valid=%0b colour=%0d pc=%0d oc=%0d expected 1 0 0 0 0",
                  busy, rd_valid, rd_colour, plot_count, oob_count);
      end
      rst = 1'b0;
      repeat (50) tick();
      read_px("read_during_init", 0, 0, 3'b000);
      tick();
      vectors++;
      if (rd_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_drop: got %0b expected 0", rd_valid);
      end
      // Abort mid-INIT with a read result pending.
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_colour !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_mid_init: got busy=%0b valid=%0b colour=%0d expected 1 0 0",
                  busy, rd_valid, rd_colour);
      end
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_init_length();
      count_busy("init_length");
      read_px("read_0_0", 0, 0, 3'b000);
      read_px("read_159_119", 159, 119, 3'b000);
   endtask

   task automatic test_plot_basic();
      plot_px(30, 20, 3'b101);
      vectors++;
      if (rd_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_idle: got %0b expected 0", rd_valid);
      end
      read_px("plot_30_20", 30, 20, 3'b101);
      vectors++;
      if (plot_count !== exp_cnt(1)) begin
         miscompares++;
         $display("FAIL plot_count_1: got %0d expected %0d", plot_count, exp_cnt(1));
      end
   endtask

   task automatic test_oob();
      plot_px(160, 5, 3'b111);
      plot_px(5, 120, 3'b111);
      vectors++;
      if (oob_count !== exp_cnt(2) || plot_count !== exp_cnt(1)) begin
         miscompares++;
         $display("FAIL oob_counts: got oc=%0d pc=%0d expected oc=%0d pc=%0d",
                  oob_count, plot_count, exp_cnt(2), exp_cnt(1));
      end
      read_px("oob_keep_159_119", 159, 119, 3'b000);
      read_px("oob_read", 200, 127, 3'b000);
   endtask

   task automatic test_back_to_back();
      int xs [5] = '{0, 159, 0, 159, 1};
      int ys [5] = '{0, 0, 119, 119, 1};
      logic [2:0] cs [5] = '{3'd1, 3'd2, 3'd4, 3'd7, 3'd6};
      for (int i = 0; i < 5; i++) begin
         vga_plot = 1'b1; vga_x = 8'(xs[i]); vga_y = 7'(ys[i]); vga_colour = cs[i];
         tick();
      end
      vga_plot = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_req = 1'b1; rd_x = 8'(xs[i]); rd_y = 7'(ys[i]);
         tick();
         vectors++;
         if (rd_valid !== 1'b1 || rd_colour !== cs[i]) begin
            miscompares++;
            $display("FAIL b2b_read_%0d: got valid=%0b colour=%0d expected valid=1 colour=%0d",
                     i, rd_valid, rd_colour, cs[i]);
         end
      end
      rd_req = 1'b0;
      vectors++;
      if (plot_count !== exp_cnt(6)) begin
         miscompares++;
         $display("FAIL plot_count_6: got %0d expected %0d", plot_count, exp_cnt(6));
      end
   endtask

   task automatic test_bypass();
      vga_plot = 1'b1; vga_x = 8'd80; vga_y = 7'd60; vga_colour = 3'b010;
      rd_req = 1'b1; rd_x = 8'd80; rd_y = 7'd60;
      tick();
      vectors++;
      if (rd_valid !== 1'b1 || rd_colour !== 3'b010) begin
         miscompares++;
         $display("FAIL bypass_hit: got valid=%0b colour=%0d expected valid=1 colour=2",
                  rd_valid, rd_colour);
      end
      // Neighbouring write must not be forwarded.
      vga_x = 8'd81; vga_colour = 3'b011;
      tick();
      vga_plot = 1'b0; rd_req = 1'b0;
      vectors++;
      if (rd_colour !== 3'b010) begin
         miscompares++;
         $display("FAIL bypass_miss: got %0d expected 2", rd_colour);
      end
      read_px("read_81_60", 81, 60, 3'b011);
      vectors++;
      if (plot_count !== exp_cnt(8)) begin
         miscompares++;
         $display("FAIL plot_count_8: got %0d expected %0d", plot_count, exp_cnt(8));
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 32768; i++) begin
         vga_plot = 1'b1; vga_x = 8'(i % 160); vga_y = 7'((i / 160) % 120);
         vga_colour = 3'(i);
         tick();
         if ((i % 8192) == 0) begin
            vectors++;
            if (plot_count !== exp_cnt(9 + i) || oob_count !== exp_cnt(2)) begin
               miscompares++;
               $display("FAIL sat_progress_%0d: got pc=%0d oc=%0d expected pc=%0d oc=%0d",
                        i, plot_count, oob_count, exp_cnt(9 + i), exp_cnt(2));
            end
         end
      end
      vga_plot = 1'b0;
      vectors++;
      if (plot_count !== exp_cnt(32767)) begin
         miscompares++;
         $display("FAIL sat_hold: got %0d expected %0d", plot_count, exp_cnt(32767));
      end
      plot_px(3, 3, 3'b001);
      vectors++;
      if (plot_count !== exp_cnt(32767) || oob_count !== exp_cnt(2)) begin
         miscompares++;
         $display("FAIL sat_no_wrap: got pc=%0d oc=%0d expected pc=%0d oc=%0d",
                  plot_count, oob_count, exp_cnt(32767), exp_cnt(2));
      end
   endtask

   task automatic test_clr();
      int n = 0;
      for (int i = 0; i < 10; i++) plot_px(10 + i, 10, 3'(1 + (i % 7)));
      read_px("pre_clr_12_10", 12, 10, 3'd3);
      clr = 1'b1;
      vga_plot = 1'b1; vga_x = 8'd50; vga_y = 7'd50; vga_colour = 3'b101;
      tick();
      clr = 1'b0; vga_plot = 1'b0;
      vectors++;
      if (busy !== 1'b1 || plot_count !== 15'd0 || oob_count !== 15'd0) begin
         miscompares++;
         $display("FAIL clr_state: got busy=%0b pc=%0d oc=%0d expected 1 0 0",
                  busy, plot_count, oob_count);
      end
      while (busy === 1'b1 && n < 40000) begin
         n++;
         if (n == 4) begin
            vga_plot = 1'b0;
            vectors++;
            if (oob_count !== exp_cnt(1) || plot_count !== 15'd0) begin
               miscompares++;
               $display("FAIL init_plot_drop: got oc=%0d pc=%0d expected oc=%0d pc=0",
                        oob_count, plot_count, exp_cnt(1));
            end
         end
         if (n == 3) begin
            vga_plot = 1'b1; vga_x = 8'd20; vga_y = 7'd20; vga_colour = 3'b111;
         end
         tick();
      end
      vectors++;
      if (n != 19200) begin
         miscompares++;
         $display("FAIL clr_init_length: got busy cycles=%0d expected 19200", n);
      end
      for (int i = 0; i < 10; i++) read_px("post_clr_read", 10 + i, 10, 3'b000);
      read_px("post_clr_50_50", 50, 50, 3'b000);
      read_px("post_clr_20_20", 20, 20, 3'b000);
   endtask

   initial begin
      test_reset();
      test_init_length();
      test_plot_basic();
      test_oob();
      test_back_to_back();
      test_bypass();
      test_saturation();
      test_clr();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter INIT_COLOUR, default 3'b000, is the colour written to every pixel during INIT.
REQ-002 clk  input  1  single clock; all state advances on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 vga_x  input  8  plot column (valid 0..159).
REQ-005 vga_y  input  7  plot row (valid 0..119).
REQ-006 vga_colour  input  3  plot colour.
REQ-007 vga_plot  input  1  write strobe; one pixel is written per cycle while high.
REQ-008 clr  input  1  synchronous request to re-initialise the framebuffer.
REQ-009 rd_req  input  1  readback request.
REQ-010 rd_x  input  8  readback column.
REQ-011 rd_y  input  7  readback row.
REQ-012 rd_valid  output  1  rd_colour is valid this cycle.
REQ-013 rd_colour  output  3  readback pixel colour.
REQ-014 busy  output  1  high while in INIT.
REQ-015 plot_count  output  15  count of accepted in-range writes.
REQ-016 oob_count  output  15  count of out-of-range or dropped plot strobes.

Function
REQ-017 FSM has two states: INIT (sweeps addresses 0..19199 at one per cycle, writing INIT_COLOUR) and ACTIVE.
REQ-018 INIT lasts exactly 19200 cycles, then moves to ACTIVE; busy = (state == INIT).
REQ-019 Address = y*160 + x, computed at 15 bits with no truncation.
REQ-020 In ACTIVE, vga_plot with x<160 and y<120 writes colour and increments plot_count.
REQ-021 In ACTIVE, vga_plot with x>=160 or y>=120 writes nothing and increments oob_count.
REQ-022 vga_plot during INIT is dropped and increments oob_count.
REQ-023 Readback latency: rd_req in cycle N gives rd_valid=1 and rd_colour in cycle N+1.
REQ-024 An out-of-range readback, or any readback during INIT, returns rd_valid=1 with rd_colour=INIT_COLOUR.
REQ-025 A readback and a write to the same address in the same cycle return the newly written colour (write-first bypass).
REQ-026 Both counters saturate at 32767 and do not wrap.
REQ-027 clr in any state restarts INIT at address 0 on the next cycle and zeroes both counters.
REQ-028 clr and vga_plot in the same cycle: clr wins, and the plot is not counted.

Reset
REQ-029 While rst is high: state=INIT, sweep address=0, busy=1, rd_valid=0, rd_colour=0, plot_count=0, oob_count=0.
REQ-030 Framebuffer contents are not reset directly; INIT rewrites them after rst deasserts.
REQ-031 rst asserted mid-INIT or mid-ACTIVE aborts all activity immediately, and the sweep restarts from address 0.

Configuration
REQ-032 With macro PLOT_SINK_STATS_EN defined, plot_count and oob_count behave as in REQ-020..REQ-028.
REQ-033 Without PLOT_SINK_STATS_EN, no counter registers exist and both outputs are constant 0; all other behaviour is unchanged.

Structure
REQ-034 Package plot_sink_pkg holds SCREEN_W=160, SCREEN_H=120, FB_DEPTH=19200, the colour_t (3-bit) typedef and the state enum.
REQ-035 Sub-module fb_ram is a simple dual-port RAM (one write port, one registered read port, 19200x3).
REQ-036 The write-first bypass (REQ-025) is implemented in plot_sink, not in fb_ram.

Verification
REQ-037 Release rst -> busy=1 for exactly 19200 cycles, then 0; reading (0,0) and (159,119) returns 3'b000.
REQ-038 After INIT, plot (30,20,3'b101) -> next-cycle read of (30,20) gives 3'b101 with rd_valid one cycle after rd_req; plot_count=1.
REQ-039 Plot (160,5) and (5,120) -> oob_count=2, plot_count unchanged; read (159,119) still returns INIT_COLOUR.
REQ-040 Same-cycle plot and read of (80,60,3'b010) -> rd_colour=3'b010.
REQ-041 Assert clr mid-ACTIVE after 10 plots -> counters=0, busy=1 for 19200 cycles, previously plotted pixels read INIT_COLOUR.
REQ-042 Force 32768 in-range plots -> plot_count holds at 32767; with PLOT_SINK_STATS_EN undefined, both counters read 0 throughout.
